alu_ctrl_stage: RTL and testbench
=================================

// Module: alu_ctrl_stage
// PURPOSE
//  Producer side of the ALU Operation interface. Decodes ALUOp/funct3/funct7 from the ID stage
//  into the 4-bit ALU opcode, branch-invert and illegal flags. Registered valid/ready stage with
//  a 2-entry skid buffer, so ID->EX backpressure never forms a combinational ready path.
// PARAMETERS
//  OPCODE_LENGTH  4   width of Operation; must match the ALU
//  TAG_WIDTH      5   sideband carried unchanged with each op (e.g. rd index)
// PORTS
//  clk         in   1              clock; all state on posedge
//  reset       in   1              synchronous, active-high
//  flush       in   1              drop all held and incoming ops this cycle
//  in_valid    in   1              decode fields valid
//  in_ready    out  1              stage can accept; transfer = in_valid & in_ready
//  alu_op      in   2              00 addr-add, 01 branch, 10 R/I arith, 11 LUI
//  funct3      in   3              instruction funct3
//  funct7      in   7              instruction funct7 (only bit 5 used)
//  is_rtype    in   1              1 = R-type (enables SUB), 0 = I-type
//  in_tag      in   TAG_WIDTH      sideband in
//  out_valid   out  1              Operation/flags valid toward EX
//  out_ready   in   1              EX accepts; transfer = out_valid & out_ready
//  Operation   out  OPCODE_LENGTH  ALU opcode
//  br_invert   out  1              branch taken when ALU result == 0 (BNE, BGE)
//  illegal     out  1              unsupported encoding; Operation forced to ADD
//  out_tag     out  TAG_WIDTH      sideband out
// BEHAVIOUR
//  Opcodes: AND 0000, SUB 0001, ADD 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111,
//   EQ 1000, SLT 1001. 1010-1111 are never emitted.
//  Decode (pure function, registered on accept):
//   alu_op 00, 11 -> ADD.
//   alu_op 01: f3 000 EQ/inv0, 001 EQ/inv1, 100 SLT/inv0, 101 SLT/inv1; other f3 -> illegal.
//   alu_op 10: f3 000 ADD, or SUB if is_rtype & f7[5]; 001 SLL; 010 SLT; 100 XOR;
//    101 SRL, or SRA if f7[5]; 110 OR; 111 AND; 011 (SLTU) -> illegal.
//   br_invert = 0 unless alu_op = 01. illegal forces Operation = ADD, br_invert = 0.
//  Latency: accepted op appears on outputs the next cycle. Outputs hold stable while
//   out_valid & !out_ready.
//  Skid FSM (state is the number of held entries):
//   EMPTY: in_ready=1, out_valid=0. Accept -> BUSY.
//   BUSY: in_ready=1, out_valid=1.
//    Accept & !out_ready -> FULL (new op into skid).
//    Accept & out_ready -> BUSY (new op into main).
//    !accept & out_ready -> EMPTY.
//   FULL: in_ready=0, out_valid=1. out_ready -> BUSY (skid moves to main, same cycle).
//  Order is strictly FIFO; no op is duplicated or lost outside flush.
//  flush: next state EMPTY and out_valid=0; an op offered in the same cycle is discarded.
//   out_ready in a flush cycle is ignored.
//  reset (overrides flush): state EMPTY; out_valid=0, Operation=0000, br_invert=0,
//   illegal=0, out_tag=0. in_ready=0 while reset is high.
//  A reset asserted mid-stream drops all held ops.
// STRUCTURE
//  alu_pkg holds the following, shared with the ALU and the testbench:
//   - opcode localparams (ALU_AND..ALU_SLT);
//   - the alu_op_e enum (ADDR, BRANCH, ARITH, LUI);
//   - the skid_state_e enum (EMPTY, BUSY, FULL).
//  Sub-module alu_ctrl_skid: generic 2-entry valid/ready skid buffer, parameterised payload width.
//  The top level holds the combinational decoder and one alu_ctrl_skid instance.
//   Payload = {illegal, br_invert, Operation, tag}.
// TESTING
//  1. alu_op=10, f3=000, f7=0x20, is_rtype=1, out_ready=1
//     -> next cycle out_valid=1, Operation=0001.
//     Same with is_rtype=0 -> 0010.
//  2. alu_op=01, f3=101 -> Operation=1001, br_invert=1.
//     alu_op=01, f3=001 -> Operation=1000, br_invert=1.
//  3. alu_op=10, f3=011 -> illegal=1, Operation=0010.
//     alu_op=01, f3=010 -> illegal=1.
//  4. out_ready=0; push tags 1, 2 -> in_ready=0 after the 2nd accept and outputs hold tag 1.
//     Raise out_ready -> tags 1 then 2 on consecutive cycles, in_ready=1.
//  5. FULL state, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//     Tags 1, 2 and the flush-cycle op are never output.
//  6. reset=1 in BUSY with flush=1 -> in_ready=0 during reset.
//     Next cycle: out_valid=0, Operation=0000, illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU opcodes, decode enums and the ALUOp/funct decoder shared by the ALU control stage and its users.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b1001;

  typedef enum logic [1:0] {
    ADDR   = 2'b00,
    BRANCH = 2'b01,
    ARITH  = 2'b10,
    LUI    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  typedef struct packed {
    logic                illegal;
    logic                br_invert;
    logic [ALU_OP_W-1:0] op;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(alu_op_e aop, logic [2:0] f3, logic f7b5, logic rtype);
    alu_dec_t d;
    d = '{illegal: 1'b0, br_invert: 1'b0, op: ALU_ADD};
    case (aop)
      BRANCH: begin
        case (f3)
          3'b000:  d.op = ALU_EQ;
          3'b001:  begin d.op = ALU_EQ;  d.br_invert = 1'b1; end
          3'b100:  d.op = ALU_SLT;
          3'b101:  begin d.op = ALU_SLT; d.br_invert = 1'b1; end
          default: d.illegal = 1'b1;
        endcase
      end
      ARITH: begin
        case (f3)
          3'b000:  d.op = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  d.op = ALU_SLL;
          3'b010:  d.op = ALU_SLT;
          3'b100:  d.op = ALU_XOR;
          3'b101:  d.op = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  d.op = ALU_OR;
          3'b111:  d.op = ALU_AND;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.op = ALU_ADD;
    endcase
    // Unsupported encodings degrade to a harmless ADD with no branch inversion.
    if (d.illegal) begin
      d.op        = ALU_ADD;
      d.br_invert = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID->EX ALU operation handshake: decode fields in, ALU opcode/flags out, each side valid/ready.
interface alu_ctrl_stage_if #(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               alu_op;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic                     is_rtype;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     br_invert;
  logic                     illegal;
  logic [TAG_WIDTH-1:0]     out_tag;

  modport master (
    input  in_valid, alu_op, funct3, funct7, is_rtype, in_tag, out_ready,
    output in_ready, out_valid, Operation, br_invert, illegal, out_tag
  );

  modport slave (
    output in_valid, alu_op, funct3, funct7, is_rtype, in_tag, out_ready,
    input  in_ready, out_valid, Operation, br_invert, illegal, out_tag
  );
endinterface

// File: rtl/alu_ctrl_skid.sv
// Generic 2-entry valid/ready skid buffer; 1-cycle latency, in_ready is registered so
// downstream backpressure never reaches the upstream ready combinationally.
module alu_ctrl_skid
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_dat
);

  skid_state_e  state;
  logic         rdy_q;
  logic [W-1:0] skid_q;

  assign in_ready = rdy_q & ~reset;

  // rdy_q is 1 in EMPTY/BUSY, so a valid input there is an accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      rdy_q     <= 1'b1;
      out_valid <= 1'b0;
      out_dat   <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      rdy_q     <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            out_dat   <= in_dat;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_valid && !out_ready) begin
            skid_q <= in_dat;
            rdy_q  <= 1'b0;
            state  <= FULL;
          end else if (in_valid) begin
            out_dat <= in_dat;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            out_dat <= skid_q;
            rdy_q   <= 1'b1;
            state   <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes ALUOp/funct3/funct7 into opcode + branch-invert/illegal flags.
// Result registered one cycle after accept; 2-entry skid keeps in_ready free of out_ready paths.
module alu_ctrl_stage
  import alu_pkg::*;
#(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  alu_ctrl_stage_if.master bus
);

  localparam int PW = 2 + OPCODE_LENGTH + TAG_WIDTH;

  alu_dec_t          dec;
  logic [PW-1:0]     in_pl;
  logic [PW-1:0]     out_pl;
  logic              unused_f7;

  assign dec       = alu_decode(alu_op_e'(bus.alu_op), bus.funct3, bus.funct7[5], bus.is_rtype);
  assign unused_f7 = ^{bus.funct7[6], bus.funct7[4:0]};
  assign in_pl     = {dec.illegal, dec.br_invert, OPCODE_LENGTH'(dec.op), bus.in_tag};

  alu_ctrl_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_dat    (in_pl),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_dat   (out_pl)
  );

  assign {bus.illegal, bus.br_invert, bus.Operation, bus.out_tag} = out_pl;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table, skid ordering/backpressure, flush and reset.
module tb_alu_ctrl_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(5)) bus ();

  alu_ctrl_stage #(.OPCODE_LENGTH(4), .TAG_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.master)
  );

  typedef struct {
    logic [1:0] aop;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       rt;
    logic [3:0] op;
    logic       inv;
    logic       ill;
  } vec_t;

  vec_t vecs [0:18] = '{
    '{2'b10, 3'b000, 7'h20, 1'b1, 4'b0001, 1'b0, 1'b0},  // SUB
    '{2'b10, 3'b000, 7'h20, 1'b0, 4'b0010, 1'b0, 1'b0},  // ADDI, f7 ignored
    '{2'b10, 3'b000, 7'h00, 1'b1, 4'b0010, 1'b0, 1'b0},  // ADD
    '{2'b10, 3'b001, 7'h00, 1'b1, 4'b0101, 1'b0, 1'b0},  // SLL
    '{2'b10, 3'b010, 7'h00, 1'b0, 4'b1001, 1'b0, 1'b0},  // SLT
    '{2'b10, 3'b100, 7'h00, 1'b1, 4'b0100, 1'b0, 1'b0},  // XOR
    '{2'b10, 3'b101, 7'h00, 1'b1, 4'b0110, 1'b0, 1'b0},  // SRL
    '{2'b10, 3'b101, 7'h20, 1'b0, 4'b0111, 1'b0, 1'b0},  // SRAI
    '{2'b10, 3'b110, 7'h00, 1'b1, 4'b0011, 1'b0, 1'b0},  // OR
    '{2'b10, 3'b111, 7'h00, 1'b1, 4'b0000, 1'b0, 1'b0},  // AND
    '{2'b10, 3'b011, 7'h00, 1'b1, 4'b0010, 1'b0, 1'b1},  // SLTU illegal
    '{2'b01, 3'b000, 7'h00, 1'b0, 4'b1000, 1'b0, 1'b0},  // BEQ
    '{2'b01, 3'b001, 7'h00, 1'b0, 4'b1000, 1'b1, 1'b0},  // BNE
    '{2'b01, 3'b100, 7'h00, 1'b0, 4'b1001, 1'b0, 1'b0},  // BLT
    '{2'b01, 3'b101, 7'h00, 1'b0, 4'b1001, 1'b1, 1'b0},  // BGE
    '{2'b01, 3'b010, 7'h00, 1'b0, 4'b0010, 1'b0, 1'b1},  // illegal branch
    '{2'b01, 3'b111, 7'h00, 1'b0, 4'b0010, 1'b0, 1'b1},  // BGEU illegal
    '{2'b00, 3'b111, 7'h20, 1'b1, 4'b0010, 1'b0, 1'b0},  // address add
    '{2'b11, 3'b101, 7'h20, 1'b1, 4'b0010, 1'b0, 1'b0}   // LUI
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic rt, input logic [4:0] tag);
    bus.in_valid = v;
    bus.alu_op   = aop;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.is_rtype = rt;
    bus.in_tag   = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the stage FULL holding tags 1 (main) and 2 (skid), out_ready low.
  task automatic fill_two();
    bus.out_ready = 1'b0;
    set_in(1'b1, 2'b10, 3'b000, 7'h00, 1'b0, 5'd1);
    step();
    bus.in_tag = 5'd2;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 5'd0);
    step();
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_operation", 32'(bus.Operation), 32'd0);
    check("rst_br_invert", 32'(bus.br_invert), 32'd0);
    check("rst_illegal",   32'(bus.illegal),   32'd0);
    check("rst_out_tag",   32'(bus.out_tag),   32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready",  32'(bus.in_ready),  32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Decode table, one op at a time with out_ready high.
    for (int i = 0; i < 19; i++) begin
      set_in(1'b1, vecs[i].aop, vecs[i].f3, vecs[i].f7, vecs[i].rt, 5'(i + 3));
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("dec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("dec%0d_op", i),    32'(bus.Operation), 32'(vecs[i].op));
      check($sformatf("dec%0d_inv", i),   32'(bus.br_invert), 32'(vecs[i].inv));
      check($sformatf("dec%0d_ill", i),   32'(bus.illegal),   32'(vecs[i].ill));
      check($sformatf("dec%0d_tag", i),   32'(bus.out_tag),   32'(i + 3));
      step();
    end
    @(negedge clk);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Back-to-back streaming with no backpressure.
    set_in(1'b1, 2'b10, 3'b110, 7'h00, 1'b1, 5'd10);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) bus.in_tag = 5'(11 + i);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("stream%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("stream%0d_tag", i),   32'(bus.out_tag),   32'(10 + i));
      check($sformatf("stream%0d_rdy", i),   32'(bus.in_ready),  32'd1);
      step();
    end
    @(negedge clk);
    check("stream_end_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Backpressure: two ops fill the stage, outputs hold, then drain in order.
    fill_two();
    @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready),  32'd0);
    check("full_valid",    32'(bus.out_valid), 32'd1);
    check("full_tag",      32'(bus.out_tag),   32'd1);
    step();
    @(negedge clk);
    check("hold_tag",   32'(bus.out_tag),   32'd1);
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain0_tag", 32'(bus.out_tag), 32'd1);
    step();
    @(negedge clk);
    check("drain1_tag",      32'(bus.out_tag),   32'd2);
    check("drain1_valid",    32'(bus.out_valid), 32'd1);
    check("drain1_in_ready", 32'(bus.in_ready),  32'd1);
    step();
    @(negedge clk);
    check("drain2_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Flush from FULL with a new op offered in the same cycle.
    fill_two();
    set_in(1'b1, 2'b01, 3'b101, 7'h00, 1'b0, 5'd9);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid",    32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready),  32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check($sformatf("post_flush%0d_valid", i), 32'(bus.out_valid), 32'd0);
    end
    step();

    // Reset (with flush) while BUSY holding a non-zero opcode.
    bus.out_ready = 1'b0;
    set_in(1'b1, 2'b01, 3'b101, 7'h00, 1'b0, 5'd4);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("busy_op", 32'(bus.Operation), 32'(ALU_SLT));
    step();
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("post_rst_valid",    32'(bus.out_valid), 32'd0);
    check("post_rst_op",       32'(bus.Operation), 32'd0);
    check("post_rst_illegal",  32'(bus.illegal),   32'd0);
    check("post_rst_inv",      32'(bus.br_invert), 32'd0);
    check("post_rst_tag",      32'(bus.out_tag),   32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready),  32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
